uart_tx_arbiter: RTL and testbench

- Shares the single board UART TX pin between the debug-bridge UART and the application UART at whole-frame granularity.
- Replaces the plain AND-combining of the two streams, which corrupts both frames when they overlap.
- Sits in the clk_w domain between the two fpga_top serial outputs and the IOB output flop.
- The first line to start a frame owns the pin for that frame plus a hold window. Frames from the other line are discarded and counted.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_timer.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and cycle-count helper for the UART TX arbiter
// Purpose: FSM state encoding, one-hot grant encodings and bit-time arithmetic
//          used by uart_tx_arbiter and uart_frame_timer.
// Ports:   none (package).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_DBG  = 2'b01;
  localparam logic [1:0] GNT_UART = 2'b10;

  // Clock cycles spanned by a number of bit-times at the given line rate.
  function automatic int unsigned cyc_count(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned bits);
    return (clk_hz / baud) * bits;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_timer.sv
// rtl/uart_tx_arbiter_timer.sv - per-line falling-edge detector and frame-length timer
// Purpose: detects the start bit of a UART frame on one line and times the frame.
// Ports:
//   clk_w, rst_sys_w : clock, asynchronous active-high reset
//   line_i           : serial line being watched
//   start_o          : comb pulse, falling edge seen while the timer is idle
//   busy_o           : timer running (frame in progress after its first cycle)
//   done_o           : pulse on the last cycle of the frame
module uart_frame_timer
  import uart_arb_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 1000000,
  parameter int unsigned FRAME_BITS = 10
) (
  input  logic clk_w,
  input  logic rst_sys_w,
  input  logic line_i,
  output logic start_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned FRAME_CYC = cyc_count(CLK_HZ, BAUD, FRAME_BITS);
  localparam int CNT_W = $clog2(FRAME_CYC + 1);

  logic             prev;
  logic [CNT_W-1:0] cnt;

  // The start cycle is the first frame cycle, so the counter holds the
  // remaining FRAME_CYC-1 cycles and the next start is accepted right after.
  assign busy_o  = (cnt != '0);
  assign start_o = prev & ~line_i & ~busy_o;
  assign done_o  = (cnt == CNT_W'(1));

  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= line_i;
      if (start_o) begin
        cnt <= CNT_W'(FRAME_CYC - 1);
      end else if (busy_o) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - whole-frame arbiter sharing one UART TX pin between two sources
// Purpose: the first line to start a frame owns the pin for that frame plus a hold
//          window; frames starting on the other line meanwhile are discarded and counted.
// Ports:
//   clk_w, rst_sys_w : clock, asynchronous active-high reset
//   dbg_txd_i        : debug UART serial out (line 0, wins ties)
//   uart_txd_i       : application UART serial out (line 1)
//   drop_clr_i       : synchronous clear of drop_cnt_o
//   txd_o            : registered pin output, granted input delayed one cycle
//   grant_o          : one-hot owner, 01 dbg, 10 uart, 00 none
//   busy_o           : grant_o is not 00
//   drop_cnt_o       : saturating count of discarded frames
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD       = 1000000,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned HOLD_BITS  = 20
) (
  input  logic       clk_w,
  input  logic       rst_sys_w,
  input  logic       dbg_txd_i,
  input  logic       uart_txd_i,
  input  logic       drop_clr_i,
  output logic       txd_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic [7:0] drop_cnt_o
);

  localparam int unsigned HOLD_CYC = cyc_count(CLK_HZ, BAUD, HOLD_BITS);
  localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  logic dbg_start, dbg_busy, dbg_done;
  logic uart_start, uart_busy, uart_done;
  logic owner_line, owner_start, owner_done, drop_hit;
  logic unused_busy;

  arb_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;

  uart_frame_timer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_BITS(FRAME_BITS)) u_dbg_timer (
    .clk_w(clk_w), .rst_sys_w(rst_sys_w), .line_i(dbg_txd_i),
    .start_o(dbg_start), .busy_o(dbg_busy), .done_o(dbg_done)
  );

  uart_frame_timer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_BITS(FRAME_BITS)) u_uart_timer (
    .clk_w(clk_w), .rst_sys_w(rst_sys_w), .line_i(uart_txd_i),
    .start_o(uart_start), .busy_o(uart_busy), .done_o(uart_done)
  );

  // A running timer already suppresses start, so the arbiter needs no busy flag.
  assign unused_busy = dbg_busy ^ uart_busy;

  // Only meaningful while a grant is held.
  assign owner_line  = grant_o[0] ? dbg_txd_i  : uart_txd_i;
  assign owner_start = grant_o[0] ? dbg_start  : uart_start;
  assign owner_done  = grant_o[0] ? dbg_done   : uart_done;

  // A start on the line that is not (or will not be) the owner this cycle.
  assign drop_hit = ((grant_o == GNT_DBG)  && uart_start) ||
                    ((grant_o == GNT_UART) && dbg_start)  ||
                    ((grant_o == GNT_NONE) && dbg_start && uart_start);

  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      state    <= IDLE;
      grant_o  <= GNT_NONE;
      busy_o   <= 1'b0;
      txd_o    <= 1'b1;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The start bit itself is forwarded on the grant cycle.
          if (dbg_start) begin
            state   <= FRAME;
            grant_o <= GNT_DBG;
            busy_o  <= 1'b1;
            txd_o   <= dbg_txd_i;
          end else if (uart_start) begin
            state   <= FRAME;
            grant_o <= GNT_UART;
            busy_o  <= 1'b1;
            txd_o   <= uart_txd_i;
          end else begin
            txd_o <= 1'b1;
          end
        end
        FRAME: begin
          txd_o <= owner_line;
          if (owner_done) begin
            if (HOLD_CYC == 0) begin
              state   <= IDLE;
              grant_o <= GNT_NONE;
              busy_o  <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(HOLD_CYC);
            end
          end
        end
        HOLD: begin
          // An owner start beats expiry on the same cycle.
          if (owner_start) begin
            state <= FRAME;
            txd_o <= owner_line;
          end else if (hold_cnt == '0) begin
            state   <= IDLE;
            grant_o <= GNT_NONE;
            busy_o  <= 1'b0;
            txd_o   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            txd_o    <= owner_line;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= GNT_NONE;
          busy_o  <= 1'b0;
          txd_o   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      drop_cnt_o <= 8'd0;
    end else if (drop_clr_i) begin
      drop_cnt_o <= 8'd0;
    end else if (drop_hit && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter against a frame-lease model
module tb_uart_tx_arbiter;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD = 1000000;
  localparam int FRAME_BITS = 10;
  localparam int HOLD_BITS = 20;
  localparam int BIT = CLK_HZ / BAUD;
  localparam int F = FRAME_BITS * BIT;
  localparam int G = F + HOLD_BITS * BIT;
  localparam int NMAX = 66000;

  logic clk_w = 1'b0;
  logic rst_sys_w = 1'b1;
  logic dbg_txd_i = 1'b1;
  logic uart_txd_i = 1'b1;
  logic drop_clr_i = 1'b0;
  logic txd_o;
  logic [1:0] grant_o;
  logic busy_o;
  logic [7:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  logic dbg_w [NMAX];
  logic uart_w [NMAX];
  logic clr_w [NMAX];
  logic [11:0] obs [NMAX];
  logic [11:0] exp_v [NMAX];
  int n_cyc;

  uart_tx_arbiter dut (
    .clk_w(clk_w), .rst_sys_w(rst_sys_w), .dbg_txd_i(dbg_txd_i), .uart_txd_i(uart_txd_i),
    .drop_clr_i(drop_clr_i), .txd_o(txd_o), .grant_o(grant_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #20 clk_w = ~clk_w;

  task automatic clear_waves(input int n);
    n_cyc = n;
    for (int i = 0; i < n; i++) begin
      dbg_w[i] = 1'b1;
      uart_w[i] = 1'b1;
      clr_w[i] = 1'b0;
    end
  endtask

  task automatic put_frame(input int line, input int t0, input logic [7:0] data);
    for (int b = 0; b < FRAME_BITS; b++) begin
      logic v;
      v = (b == 0) ? 1'b0 : (b == FRAME_BITS - 1) ? 1'b1 : data[b-1];
      for (int c = 0; c < BIT; c++) begin
        if (t0 + b * BIT + c < n_cyc) begin
          if (line == 0) dbg_w[t0 + b * BIT + c] = v;
          else uart_w[t0 + b * BIT + c] = v;
        end
      end
    end
  endtask

  // Lease model: a frame start on a free pin takes it for G cycles; each owner
  // start renews the lease; other-line starts while leased are drops.
  task automatic build_model();
    logic p0, p1, s0, s1, hit, tx;
    logic [1:0] g;
    int bu0, bu1, owner, lease, drop;
    p0 = 1'b0; p1 = 1'b0; bu0 = 0; bu1 = 0; owner = 0; lease = 0; drop = 0;
    for (int t = 0; t < n_cyc; t++) begin
      s0 = p0 && !dbg_w[t] && (t >= bu0);
      s1 = p1 && !uart_w[t] && (t >= bu1);
      if (s0) bu0 = t + F;
      if (s1) bu1 = t + F;
      p0 = dbg_w[t];
      p1 = uart_w[t];
      hit = 1'b0;
      if (owner == 0) begin
        if (s0) begin owner = 1; lease = t + G; hit = s1; end
        else if (s1) begin owner = 2; lease = t + G; end
      end else begin
        hit = (owner == 1) ? s1 : s0;
        if ((owner == 1 && s0) || (owner == 2 && s1)) lease = t + G;
        else if (t >= lease) owner = 0;
      end
      if (clr_w[t]) drop = 0;
      else if (hit && drop < 255) drop++;
      g = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      tx = (owner == 1) ? dbg_w[t] : (owner == 2) ? uart_w[t] : 1'b1;
      exp_v[t] = {tx, g, |g, 8'(drop)};
    end
  endtask

  task automatic apply_reset();
    rst_sys_w = 1'b1;
    dbg_txd_i = 1'b1;
    uart_txd_i = 1'b1;
    drop_clr_i = 1'b0;
    repeat (3) @(posedge clk_w);
    @(negedge clk_w);
    rst_sys_w = 1'b0;
  endtask

  task automatic run_waves();
    build_model();
    apply_reset();
    for (int t = 0; t < n_cyc; t++) begin
      dbg_txd_i = dbg_w[t];
      uart_txd_i = uart_w[t];
      drop_clr_i = clr_w[t];
      @(posedge clk_w);
      #1 obs[t] = {txd_o, grant_o, busy_o, drop_cnt_o};
      @(negedge clk_w);
    end
    drop_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_sys_w = 1'b1;
    dbg_txd_i = 1'b0;
    uart_txd_i = 1'($urandom);
    @(posedge clk_w);
    #1;
    checks++; if (txd_o !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd_o); end
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (drop_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_single_dbg();
    int shown;
    clear_waves(900);
    put_frame(0, 10, 8'h55);
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL single t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
    checks++; if (obs[9][10:9] !== 2'b00) begin errors++; $display("FAIL single_pre got %b want 00", obs[9][10:9]); end
    checks++; if (obs[10][11:9] !== 3'b001) begin errors++; $display("FAIL single_grant got %b want 001", obs[10][11:9]); end
    checks++; if (obs[759][10:9] !== 2'b01) begin errors++; $display("FAIL single_last got %b want 01", obs[759][10:9]); end
    checks++; if (obs[760][10:8] !== 3'b000) begin errors++; $display("FAIL single_end got %b want 000", obs[760][10:8]); end
    checks++; if (obs[899][7:0] !== 8'd0) begin errors++; $display("FAIL single_drop got %0d want 0", obs[899][7:0]); end
  endtask

  task automatic test_collision();
    int shown;
    logic [7:0] d;
    d = 8'($urandom);
    clear_waves(900);
    put_frame(0, 10, d);
    put_frame(1, 10, ~d);
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL collision t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
    checks++; if (obs[20][10:9] !== 2'b01) begin errors++; $display("FAIL collision_grant got %b want 01", obs[20][10:9]); end
    checks++; if (obs[899][7:0] !== 8'd1) begin errors++; $display("FAIL collision_drop got %0d want 1", obs[899][7:0]); end
  endtask

  task automatic test_late_dbg();
    int shown;
    clear_waves(1300);
    put_frame(1, 10, 8'($urandom));
    put_frame(0, 110, 8'($urandom));
    put_frame(0, 360, 8'($urandom));
    put_frame(0, 610, 8'($urandom));
    put_frame(0, 1000, 8'($urandom));
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL late_dbg t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
    checks++; if (obs[200][7:0] !== 8'd1) begin errors++; $display("FAIL late_drop got %0d want 1", obs[200][7:0]); end
    checks++; if (obs[800][10:9] !== 2'b00) begin errors++; $display("FAIL late_nogrant got %b want 00", obs[800][10:9]); end
    checks++; if (obs[1000][10:9] !== 2'b01) begin errors++; $display("FAIL late_regrant got %b want 01", obs[1000][10:9]); end
  endtask

  task automatic test_back_to_back();
    int shown;
    clear_waves(1200);
    put_frame(1, 10, 8'($urandom));
    put_frame(1, 10 + F + 40, 8'($urandom));
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL b2b t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
    shown = 0;
    for (int t = 10; t < 10 + F + 40 + G; t++) begin
      checks++;
      if (obs[t][10:9] !== 2'b10) begin
        errors++;
        if (shown < 4) $display("FAIL b2b_grant t=%0d got %b want 10", t, obs[t][10:9]);
        shown++;
      end
    end
    checks++; if (obs[1199][7:0] !== 8'd0) begin errors++; $display("FAIL b2b_drop got %0d want 0", obs[1199][7:0]); end
  endtask

  task automatic test_random();
    int shown, t0;
    clear_waves(5000);
    for (int ln = 0; ln < 2; ln++) begin
      t0 = $urandom_range(5, 200);
      while (t0 + F < n_cyc) begin
        put_frame(ln, t0, 8'($urandom));
        t0 = t0 + F + $urandom_range(0, 900);
      end
    end
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL random t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int shown;
    clear_waves(140);
    put_frame(0, 10, 8'($urandom) & 8'hF7);
    apply_reset();
    for (int t = 0; t <= 130; t++) begin
      dbg_txd_i = dbg_w[t];
      @(posedge clk_w);
      if (t < 130) @(negedge clk_w);
    end
    #1;
    checks++; if ({txd_o, grant_o} !== 3'b001) begin errors++; $display("FAIL rstmid_pre got %b want 001", {txd_o, grant_o}); end
    #2 rst_sys_w = 1'b1;
    #1;
    checks++; if ({txd_o, grant_o, busy_o} !== 4'b1000) begin errors++; $display("FAIL rstmid_async got %b want 1000", {txd_o, grant_o, busy_o}); end
    dbg_txd_i = 1'b0;
    repeat (4) @(posedge clk_w);
    @(negedge clk_w);
    rst_sys_w = 1'b0;
    shown = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk_w);
      #1;
      checks++;
      if ({txd_o, grant_o} !== 3'b100) begin
        errors++;
        if (shown < 4) $display("FAIL rstmid_stuck t=%0d got %b want 100", t, {txd_o, grant_o});
        shown++;
      end
    end
    @(negedge clk_w);
    dbg_txd_i = 1'b1;
    repeat (5) @(negedge clk_w);
    dbg_txd_i = 1'b0;
    @(posedge clk_w);
    #1;
    checks++; if ({txd_o, grant_o} !== 3'b001) begin errors++; $display("FAIL rstmid_fresh got %b want 001", {txd_o, grant_o}); end
    @(negedge clk_w);
    dbg_txd_i = 1'b1;
  endtask

  task automatic test_saturate();
    int shown, tc;
    tc = 11 + F * 261;
    clear_waves(tc + 39);
    for (int i = 0; 10 + 2 * F * i + F < n_cyc; i++) put_frame(0, 10 + 2 * F * i, 8'($urandom));
    for (int j = 0; j <= 261; j++) put_frame(1, 11 + F * j, 8'($urandom));
    clr_w[tc] = 1'b1;
    run_waves();
    shown = 0;
    for (int t = 0; t < n_cyc; t++) begin
      checks++;
      if (obs[t] !== exp_v[t]) begin
        errors++;
        if (shown < 4) $display("FAIL saturate t=%0d got %h want %h", t, obs[t], exp_v[t]);
        shown++;
      end
    end
    checks++; if (obs[tc-1][7:0] !== 8'd255) begin errors++; $display("FAIL sat_max got %0d want 255", obs[tc-1][7:0]); end
    checks++; if (obs[tc][7:0] !== 8'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", obs[tc][7:0]); end
  endtask

  initial begin
    test_reset();
    test_single_dbg();
    test_collision();
    test_late_dbg();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
